// File: rtl/kia_pkg.sv
// Shared constants for the keyboard interface adapter: register map,
// status bit positions and PS/2 frame length.
package kia_pkg;

   localparam logic KIA_STATUS = 1'b0;
   localparam logic KIA_DATA   = 1'b1;

   localparam int ST_NOT_EMPTY = 0;
   localparam int ST_FULL      = 1;
   localparam int ST_OVF       = 2;
   localparam int ST_ERR       = 3;

   localparam int FRAME_BITS = 11;

endpackage

// File: rtl/kia_ps2_rx.sv
// PS/2 receiver: synchronizes the line pair, shifts one bit per falling
// clock edge and emits a one-cycle byte strobe or frame-error strobe.
module kia_ps2_rx
   import kia_pkg::*;
#(
   parameter int IDLE_TIMEOUT = 50000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_c,
   input  logic       ps2_d,
   output logic       byte_vld,
   output logic [7:0] byte_dat,
   output logic       frame_err
);

   localparam int TW = $clog2(IDLE_TIMEOUT + 1);

   logic          c_s1, c_s2, c_prev, d_s1, d_s2;
   logic          fall;
   logic [3:0]    bit_cnt;
   logic [9:0]    sr;
   logic [TW-1:0] to_cnt;
   logic          last_bit, frame_ok;

   assign fall     = c_prev & ~c_s2;
   assign last_bit = (bit_cnt == 4'(FRAME_BITS - 1));
   // sr holds start, data[7:0], parity; the live sample is the stop bit
   assign frame_ok = ~sr[0] & d_s2 & (^sr[9:1]);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         c_s1   <= 1'b1;
         c_s2   <= 1'b1;
         c_prev <= 1'b1;
         d_s1   <= 1'b1;
         d_s2   <= 1'b1;
      end else begin
         c_s1   <= ps2_c;
         c_s2   <= c_s1;
         c_prev <= c_s2;
         d_s1   <= ps2_d;
         d_s2   <= d_s1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bit_cnt   <= '0;
         sr        <= '0;
         to_cnt    <= '0;
         byte_vld  <= 1'b0;
         byte_dat  <= '0;
         frame_err <= 1'b0;
      end else begin
         byte_vld  <= 1'b0;
         frame_err <= 1'b0;
         if (fall) begin
            to_cnt <= '0;
            if (last_bit) begin
               bit_cnt   <= '0;
               byte_vld  <= frame_ok;
               frame_err <= ~frame_ok;
               byte_dat  <= sr[8:1];
            end else begin
               bit_cnt <= bit_cnt + 4'd1;
               sr      <= {d_s2, sr[9:1]};
            end
         end else if (bit_cnt != 4'd0) begin
            // A stalled partial frame is dropped silently
            if (to_cnt == TW'(IDLE_TIMEOUT)) begin
               bit_cnt <= '0;
               to_cnt  <= '0;
            end else begin
               to_cnt <= to_cnt + TW'(1);
            end
         end else begin
            to_cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/kia_keyboard_adapter.sv
// Keyboard interface adapter: bus slave with status/data registers in front
// of a scan-code FIFO fed by the PS/2 receiver.
module kia_keyboard_adapter
   import kia_pkg::*;
#(
   parameter int FIFO_DEPTH_LOG2 = 4,
   parameter int IDLE_TIMEOUT    = 50000
) (
   input  logic       CLK_I,
   input  logic       RES_I,
   input  logic       CYC_I,
   input  logic       STB_I,
   input  logic       WE_I,
   input  logic       ADR_I,
   output logic       ACK_O,
   output logic [7:0] DAT_O,
   input  logic       D_I,
   input  logic       C_I
);

   localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;

   logic                     rx_vld, rx_err;
   logic [7:0]               rx_byte;
   logic [7:0]               mem [0:DEPTH-1];
   logic [FIFO_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
   logic [FIFO_DEPTH_LOG2:0]   count;
   logic                     full, not_empty;
   logic                     ovf, err;
   logic                     acc_wr, pop, push, ovf_set, clr;
   logic [7:0]               status;

   kia_ps2_rx #(.IDLE_TIMEOUT(IDLE_TIMEOUT)) u_rx (
      .clk       (CLK_I),
      .rst       (RES_I),
      .ps2_c     (C_I),
      .ps2_d     (D_I),
      .byte_vld  (rx_vld),
      .byte_dat  (rx_byte),
      .frame_err (rx_err)
   );

   // Handshake: a request is CYC_I&STB_I; ACK_O answers one cycle later for
   // exactly one cycle, and writes take effect only in that ACK cycle.
   assign acc_wr    = ACK_O & CYC_I & STB_I & WE_I;
   assign full      = count[FIFO_DEPTH_LOG2];
   assign not_empty = |count;
   assign pop       = acc_wr & (ADR_I == KIA_DATA) & not_empty;
   assign clr       = acc_wr & (ADR_I == KIA_STATUS);
   assign push      = rx_vld & (~full | pop);
   assign ovf_set   = rx_vld & full & ~pop;

   always_ff @(posedge CLK_I or posedge RES_I) begin
      if (RES_I) begin
         ACK_O  <= 1'b0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovf    <= 1'b0;
         err    <= 1'b0;
      end else begin
         ACK_O <= CYC_I & STB_I & ~ACK_O;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push & ~pop)      count <= count + 1'b1;
         else if (pop & ~push) count <= count - 1'b1;
         ovf <= ovf_set | (ovf & ~clr);
         err <= rx_err  | (err & ~clr);
      end
   end

   always_ff @(posedge CLK_I) begin
      if (push) mem[wr_ptr] <= rx_byte;
   end

   always_comb begin
      status               = '0;
      status[ST_NOT_EMPTY] = not_empty;
      status[ST_FULL]      = full;
      status[ST_OVF]       = ovf;
      status[ST_ERR]       = err;
      if (ADR_I == KIA_DATA) DAT_O = not_empty ? mem[rd_ptr] : 8'h00;
      else                   DAT_O = status;
   end

endmodule

// File: tb/tb_kia_keyboard_adapter.sv
// Directed bench for the keyboard adapter: PS/2 frame driver, bus tasks,
// expected-value queue for FIFO order and a one-line summary.
module tb_kia_keyboard_adapter;
   import kia_pkg::*;

   localparam int TO = 200;

   logic       clk = 1'b0;
   logic       RES_I, CYC_I, STB_I, WE_I, ADR_I, D_I, C_I;
   logic       ACK_O;
   logic [7:0] DAT_O;
   logic [7:0] exp_q [$];
   int         total = 0;
   int         bad   = 0;

   kia_keyboard_adapter #(.FIFO_DEPTH_LOG2(4), .IDLE_TIMEOUT(TO)) dut (
      .CLK_I (clk),
      .RES_I (RES_I),
      .CYC_I (CYC_I),
      .STB_I (STB_I),
      .WE_I  (WE_I),
      .ADR_I (ADR_I),
      .ACK_O (ACK_O),
      .DAT_O (DAT_O),
      .D_I   (D_I),
      .C_I   (C_I)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%02h exp=%02h", tag, got, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_read(input logic adr, input logic [7:0] exp, input string tag);
      logic [7:0] d;
      @(negedge clk);
      CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b0; ADR_I = adr;
      chk({tag, "_ack_pre"}, {7'b0, ACK_O}, 8'h00);
      @(posedge clk); #1;
      chk({tag, "_ack_on"}, {7'b0, ACK_O}, 8'h01);
      d = DAT_O;
      chk(tag, d, exp);
      @(negedge clk);
      CYC_I = 1'b0; STB_I = 1'b0;
      @(posedge clk); #1;
      chk({tag, "_ack_off"}, {7'b0, ACK_O}, 8'h00);
   endtask

   task automatic bus_write(input logic adr, input string tag);
      @(negedge clk);
      CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b1; ADR_I = adr;
      @(posedge clk); #1;
      chk({tag, "_ack_on"}, {7'b0, ACK_O}, 8'h01);
      @(posedge clk); #1;
      chk({tag, "_ack_off"}, {7'b0, ACK_O}, 8'h00);
      @(negedge clk);
      CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0;
   endtask

   task automatic send_bit(input logic b);
      @(negedge clk);
      D_I = b;
      idle(3);
      C_I = 1'b0;
      idle(5);
      C_I = 1'b1;
      idle(3);
   endtask

   task automatic send_frame(input logic [7:0] data, input logic bad_par);
      logic [10:0] f;
      f = {1'b1, ~(^data) ^ bad_par, data, 1'b0};
      for (int i = 0; i < FRAME_BITS; i++) send_bit(f[i]);
      idle(10);
   endtask

   initial begin
      RES_I = 1'b1; CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0; ADR_I = 1'b0;
      D_I = 1'b1; C_I = 1'b1;
      idle(3);
      RES_I = 1'b0;
      #1;
      chk("rst_ack", {7'b0, ACK_O}, 8'h00);
      chk("rst_status", DAT_O, 8'h00);
      bus_read(KIA_STATUS, 8'h00, "st_reset");

      // single good frame
      send_frame(8'h1C, 1'b0);
      bus_read(KIA_STATUS, 8'h01, "st_one");
      bus_read(KIA_DATA, 8'h1C, "data_1c_a");
      bus_read(KIA_DATA, 8'h1C, "data_1c_b");
      bus_write(KIA_DATA, "pop_1c");
      bus_read(KIA_STATUS, 8'h00, "st_after_pop");

      // parity error
      send_frame(8'h1C, 1'b1);
      bus_read(KIA_STATUS, 8'h08, "st_err");
      bus_write(KIA_STATUS, "clr_err");
      bus_read(KIA_STATUS, 8'h00, "st_err_clr");

      // fill past capacity
      for (int i = 0; i < 17; i++) begin
         send_frame(8'(i), 1'b0);
         if (i < 16) exp_q.push_back(8'(i));
      end
      bus_read(KIA_STATUS, 8'h07, "st_full_ovf");
      while (exp_q.size() > 0) begin
         bus_read(KIA_DATA, exp_q.pop_front(), "fifo_head");
         bus_write(KIA_DATA, "fifo_pop");
      end
      bus_read(KIA_STATUS, 8'h04, "st_drained_ovf");
      bus_write(KIA_STATUS, "clr_ovf");
      bus_read(KIA_STATUS, 8'h00, "st_ovf_clr");

      // partial frame discarded by idle timeout
      for (int i = 0; i < 5; i++) send_bit(1'(i & 1));
      idle(TO + 10);
      send_frame(8'h5A, 1'b0);
      bus_read(KIA_STATUS, 8'h01, "st_after_to");
      bus_read(KIA_DATA, 8'h5A, "data_5a");
      bus_write(KIA_DATA, "pop_5a");
      bus_read(KIA_STATUS, 8'h00, "st_to_done");

      // pop on empty, then reset mid-frame with data queued
      bus_write(KIA_DATA, "pop_empty");
      bus_read(KIA_STATUS, 8'h00, "st_pop_empty");
      send_frame(8'h77, 1'b0);
      bus_read(KIA_STATUS, 8'h01, "st_pre_rst");
      for (int i = 0; i < 6; i++) send_bit(1'(i == 3));
      @(negedge clk);
      C_I = 1'b0;
      idle(2);
      RES_I = 1'b1;
      idle(2);
      C_I = 1'b1; D_I = 1'b1;
      idle(2);
      RES_I = 1'b0;
      idle(2);
      bus_read(KIA_STATUS, 8'h00, "st_post_rst");
      bus_read(KIA_DATA, 8'h00, "data_post_rst");
      idle(TO + 10);
      bus_read(KIA_STATUS, 8'h00, "st_post_rst_idle");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/kia_keyboard_adapter.md
Name: kia_keyboard_adapter

Overview:
- Keyboard Interface Adapter (KIA): a Wishbone-style 8-bit slave that receives PS/2 keyboard frames and queues the scan-code bytes in a FIFO.
- Sits on the 16-bit peripheral bus behind the CPU bridge. It is selected by the address decoder (strobe and cycle are pre-gated with the KIA enable).
- The CPU polls a status register, reads the FIFO head, and pops the head by writing.

Parameters:
- FIFO_DEPTH_LOG2, 4, log2 of the scan-code FIFO depth (default 16 entries).
- IDLE_TIMEOUT, 50000, number of CLK_I cycles with no PS/2 clock falling edge after which a partial frame is discarded (2 ms at 25 MHz).

Ports:
- CLK_I  in  1  system clock; all logic is on the rising edge.
- RES_I  in  1  asynchronous active-high reset.
- CYC_I  in  1  bus cycle in progress (pre-gated by the KIA decode).
- STB_I  in  1  bus strobe (pre-gated by the KIA decode).
- WE_I  in  1  1 = write, 0 = read.
- ADR_I  in  1  register select: 0 = STATUS, 1 = DATA.
- ACK_O  out  1  bus acknowledge.
- DAT_O  out  8  read data.
- D_I  in  1  PS/2 data line, asynchronous, idle high.
- C_I  in  1  PS/2 clock line, asynchronous, idle high.

Behaviour:
- Reset (RES_I high, asynchronous):
  - FIFO empty; read and write pointers and count = 0.
  - Sticky OVF and ERR = 0; receiver idle with bit count 0; timeout counter 0.
  - ACK_O = 0.
  - Synchronizer flops preset to 1.
  - DAT_O follows its combinational definition (STATUS reads 0x00 after reset).
- Synchronization: C_I and D_I each pass through 2 flops. A falling edge is declared when the synchronized clock was 1 last cycle and is 0 now. Data is sampled from the synchronized D on that same cycle.
- Frame format: 11 bits in order: start (0), 8 data bits LSB first, odd parity, stop (1).
  - One bit is shifted per falling edge.
  - On the 11th bit the frame is checked: start==0, stop==1, and the XOR of the 8 data bits plus the parity bit == 1.
  - A valid frame pushes the byte. An invalid frame sets ERR and pushes nothing.
  - The receiver returns to bit count 0 in both cases.
- Timeout: while the bit count is nonzero, the timeout counter increments every cycle and clears on each falling edge. When it reaches IDLE_TIMEOUT the partial frame is discarded (bit count 0). No ERR is set.
- FIFO push:
  - Push occurs in the cycle after the 11th bit is sampled.
  - If the FIFO is full and no pop occurs in that cycle, the byte is dropped and OVF is set.
  - A simultaneous push and pop while full: both take effect and the count is unchanged.
- Bus handshake:
  - ACK_O is registered: ACK_O <= CYC_I & STB_I & ~ACK_O.
  - Every access is therefore acknowledged exactly one cycle after strobe, as a one-cycle pulse.
  - A held strobe re-acknowledges every other cycle.
  - Side effects occur only in a cycle where ACK_O=1, CYC_I=1, STB_I=1 and WE_I=1.
- Read STATUS (ADR_I=0): DAT_O = {4'b0, ERR, OVF, full, not_empty}. Reads have no side effects.
- Read DATA (ADR_I=1): DAT_O = FIFO head byte, or 0x00 when empty. No pop.
- Write DATA (ADR_I=1): pops the head; no effect when empty.
- Write STATUS (ADR_I=0): clears OVF and ERR. If a new error or overflow occurs in the same cycle, setting wins.
- DAT_O is combinational from ADR_I and the current state; the master samples it while ACK_O=1.
- Pointer arithmetic: pointers are FIFO_DEPTH_LOG2 bits and wrap modulo the depth. The count is FIFO_DEPTH_LOG2+1 bits. full = (count == depth); not_empty = (count != 0).
- Reset asserted mid-frame or mid-access aborts everything immediately.

Decomposition:
- Shared package kia_pkg holds:
  - register offsets: KIA_STATUS=0, KIA_DATA=1;
  - status bit indices: ST_NOT_EMPTY=0, ST_FULL=1, ST_OVF=2, ST_ERR=3;
  - PS/2 frame length: 11.
- One sub-module, kia_ps2_rx, contains the synchronizers, edge detect, shifter, checker and timeout. It emits a one-cycle strobe with an 8-bit byte, plus a one-cycle frame-error strobe.
- The FIFO and the bus logic stay in the top-level module.

Test Plan:
- Reset, then read STATUS -> ACK_O high exactly one cycle after strobe for one cycle; DAT_O=0x00.
- Send frame for 0x1C (parity bit 0) -> STATUS reads 0x01; DATA reads 0x1C twice unchanged; write DATA -> STATUS reads 0x00.
- Send 0x1C with parity bit 1 -> STATUS reads 0x08 (FIFO empty); write STATUS -> STATUS reads 0x00.
- Send 17 valid frames 0x00..0x10 -> STATUS reads 0x07. Popping 16 times yields 0x00..0x0F, then STATUS reads 0x04.
- Send 5 bits, idle IDLE_TIMEOUT+10 cycles, then a full 0x5A frame -> STATUS reads 0x01, DATA reads 0x5A, ERR clear.
- Pop while empty -> no change, STATUS reads 0x00; assert RES_I mid-frame -> frame lost and FIFO empty.
